// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences one single-port memory shared by the boot
// loader, the data path and instruction fetch. One transaction in flight,
// fixed priority loader > data > fetch, with fetch aging so a steady data
// stream cannot starve instruction fetch indefinitely.
//
// Handshake: each requester holds xReq (with its address/data) at a level
// until it sees a one-cycle xAck; it drops xReq on the edge where it samples
// xAck=1. Inputs are captured at grant, so later changes to req/addr/data do
// not affect the transaction in flight.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              ldReq,
  input  logic [ADDR_W-1:0] ldAddr,
  input  logic [DATA_W-1:0] ldData,
  output logic              ldAck,
  input  logic              dReq,
  input  logic              dWr,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic              dAck,
  output logic [DATA_W-1:0] dRData,
  input  logic              fReq,
  input  logic [ADDR_W-1:0] fAddr,
  output logic              fAck,
  output logic [DATA_W-1:0] fRData,
  output logic              memEn,
  output logic              memWr,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  output logic              busy,
  output logic [1:0]        grantId,
  output logic [1:0]        stateDbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] ID_NONE  = 2'd0;
  localparam logic [1:0] ID_FETCH = 2'd1;
  localparam logic [1:0] ID_DATA  = 2'd2;
  localparam logic [1:0] ID_LOAD  = 2'd3;

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam int WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);
  localparam logic [WCW-1:0] WAIT_INIT  = WCW'(MEM_LAT - 1);

  logic [1:0]        state;
  logic [1:0]        curId;
  logic [1:0]        pickId;
  logic [ADDR_W-1:0] capAddr;
  logic [DATA_W-1:0] capData;
  logic              capWr;
  logic [WCW-1:0]    waitCnt;
  logic [SCW-1:0]    starveCnt;

  // Winner selection; fetch overtakes data only once it has been aged out.
  always_comb begin
    pickId = ID_NONE;
    if (ldReq) begin
      pickId = ID_LOAD;
    end else if (dReq && !(fReq && (starveCnt == STARVE_TOP))) begin
      pickId = ID_DATA;
    end else if (fReq) begin
      pickId = ID_FETCH;
    end
  end

  // Transaction FSM: capture at grant, strobe memory, wait for read data, ack.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state   <= IDLE;
      curId   <= ID_NONE;
      capAddr <= '0;
      capData <= '0;
      capWr   <= 1'b0;
      waitCnt <= '0;
      dRData  <= '0;
      fRData  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pickId != ID_NONE) begin
            state <= ISSUE;
            curId <= pickId;
            case (pickId)
              ID_LOAD: begin
                capAddr <= ldAddr;
                capData <= ldData;
                capWr   <= 1'b1;
              end
              ID_DATA: begin
                capAddr <= dAddr;
                capData <= dWData;
                capWr   <= dWr;
              end
              default: begin
                capAddr <= fAddr;
                capData <= '0;
                capWr   <= 1'b0;
              end
            endcase
          end
        end
        ISSUE: begin
          if (capWr) begin
            state <= RESP;
          end else begin
            state   <= WAIT;
            waitCnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (waitCnt == '0) begin
            state <= RESP;
            if (curId == ID_DATA) dRData <= memRData;
            if (curId == ID_FETCH) fRData <= memRData;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          curId <= ID_NONE;
        end
      endcase
    end
  end

  // Fetch aging: count data wins over a waiting fetch, clear when fetch wins.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      starveCnt <= '0;
    end else if (state == IDLE) begin
      if (pickId == ID_FETCH) begin
        starveCnt <= '0;
      end else if ((pickId == ID_DATA) && fReq && (starveCnt != STARVE_TOP)) begin
        starveCnt <= starveCnt + 1'b1;
      end
    end
  end

  // Outputs decoded from state so strobes and acks are confined to one state.
  always_comb begin
    memEn    = (state == ISSUE);
    memWr    = (state == ISSUE) && capWr;
    memAddr  = capAddr;
    memWData = capData;
    ldAck    = (state == RESP) && (curId == ID_LOAD);
    dAck     = (state == RESP) && (curId == ID_DATA);
    fAck     = (state == RESP) && (curId == ID_FETCH);
    busy     = (state != IDLE);
    grantId  = curId;
    stateDbg = state;
  end

endmodule
